// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
// Fetch and data ports share one synchronous RAM through this block.
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  localparam int DEFAULT_MEM_LATENCY = 2;
  localparam int DEFAULT_MAX_WAIT    = 4;

endpackage

// File: rtl/arbiter_priority_select.sv
// Fixed-priority port select: the data port wins a tie unless the fetch
// port has been starved long enough, in which case fetch wins.
module arbiter_priority_select
  import memory_port_arbiter_pkg::*;
(
  input  logic   if_request,
  input  logic   mem_request,
  input  logic   starve,
  output grant_e grant
);

  always_comb begin
    grant = GRANT_MEM;
    if (if_request && (!mem_request || starve)) begin
      grant = GRANT_IF;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates fetch and data accesses onto one single-ported synchronous RAM,
// counts the fixed memory latency and returns data with a one-cycle ready pulse.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int MAX_WAIT    = DEFAULT_MAX_WAIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_request,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  mem_request,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  ram_enable,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(MAX_WAIT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_WAIT);

  arb_state_e       state_q;
  arb_state_e       state_d;
  grant_e           grant_sel;
  grant_e           grant_p0;
  logic             op_write_p0;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [STV_W-1:0] starve_cnt_q;
  logic             starve;
  logic             any_req;
  logic             do_grant;
  logic             do_complete;

  function automatic logic [STV_W-1:0] starve_inc(input logic [STV_W-1:0] v);
    return (v == STV_MAX) ? v : v + STV_W'(1);
  endfunction

  assign any_req   = if_request | mem_request;
  assign starve    = (starve_cnt_q == STV_MAX);
  assign stall_if  = if_request & ~if_ready;
  assign stall_mem = mem_request & ~mem_ready;

  arbiter_priority_select u_select (
    .if_request  (if_request),
    .mem_request (mem_request),
    .starve      (starve),
    .grant       (grant_sel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = ISSUE;
          do_grant = 1'b1;
        end
      end
      ISSUE: begin
        if (MEM_LATENCY == 1) begin
          state_d     = DONE;
          do_complete = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d     = DONE;
          do_complete = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first WAIT cycle is latency count 1; the ISSUE cycle is count 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      lat_cnt_q <= LAT_W'(1);
    end else if (state_q == WAIT) begin
      lat_cnt_q <= lat_cnt_q + LAT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (!if_request) begin
        starve_cnt_q <= '0;
      end else if (do_grant) begin
        starve_cnt_q <= (grant_sel == GRANT_IF) ? '0 : starve_inc(starve_cnt_q);
      end
    end
  end

  // Grant edge: capture the winning port's request onto the RAM bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_p0       <= GRANT_IF;
      op_write_p0    <= 1'b0;
      ram_enable     <= 1'b0;
      ram_write      <= 1'b0;
      ram_address    <= '0;
      ram_write_data <= '0;
    end else begin
      ram_enable <= do_grant;
      if (do_grant) begin
        grant_p0 <= grant_sel;
        if (grant_sel == GRANT_MEM) begin
          op_write_p0    <= mem_write;
          ram_write      <= mem_write;
          ram_address    <= mem_address;
          ram_write_data <= mem_write_data;
        end else begin
          op_write_p0    <= 1'b0;
          ram_write      <= 1'b0;
          ram_address    <= if_address;
          ram_write_data <= '0;
        end
      end else begin
        ram_write <= 1'b0;
      end
    end
  end

  // Completion edge: return data to the granted port with a one-cycle ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_ready      <= 1'b0;
      if_data       <= '0;
      mem_ready     <= 1'b0;
      mem_read_data <= '0;
    end else begin
      if_ready  <= do_complete && (grant_p0 == GRANT_IF);
      mem_ready <= do_complete && (grant_p0 == GRANT_MEM);
      if (do_complete) begin
        if (grant_p0 == GRANT_IF) begin
          if_data <= ram_read_data;
        end else begin
          mem_read_data <= op_write_p0 ? '0 : ram_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a timestamp-based access model checked every
// cycle, a registered-read RAM model, and directed literal checks.
module tb_memory_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_request = 1'b0;
  logic [AW-1:0] if_address = '0;
  logic          if_ready;
  logic [DW-1:0] if_data;
  logic          mem_request = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_address = '0;
  logic [DW-1:0] mem_write_data = '0;
  logic          mem_ready;
  logic [DW-1:0] mem_read_data;
  logic          stall_if;
  logic          stall_mem;
  logic          ram_enable;
  logic          ram_write;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_write_data;
  logic [DW-1:0] ram_read_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  memory_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_LATENCY(LAT),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .if_request    (if_request),
    .if_address    (if_address),
    .if_ready      (if_ready),
    .if_data       (if_data),
    .mem_request   (mem_request),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_ready     (mem_ready),
    .mem_read_data (mem_read_data),
    .stall_if      (stall_if),
    .stall_mem     (stall_mem),
    .ram_enable    (ram_enable),
    .ram_write     (ram_write),
    .ram_address   (ram_address),
    .ram_write_data(ram_write_data),
    .ram_read_data (ram_read_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM contents: a fixed pattern plus one writable word.
  logic          wr_vld;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  function automatic logic [31:0] ram_lookup(input logic [31:0] a);
    if (wr_vld && a == wr_addr) return wr_data;
    if (a == 32'h0000_0010) return 32'h8C01_0004;
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  // Registered-read RAM: data appears the cycle after the enable cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_vld        <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      ram_read_data <= 32'hBADC_0DE1;
    end else if (ram_enable) begin
      if (ram_write) begin
        wr_vld  <= 1'b1;
        wr_addr <= ram_address;
        wr_data <= ram_write_data;
        ram_read_data <= 32'hBADC_0DE0;
      end else begin
        ram_read_data <= ram_lookup(ram_address);
      end
    end else begin
      ram_read_data <= 32'hBADC_0DE1;
    end
  end

  // Access model: each grant at edge e0 owns the RAM until edge e0+LAT+2.
  int          edge_n = 0;
  bit          m_busy;
  int          m_e0;
  bit          m_mem;
  bit          m_wr;
  int          m_starve;
  logic [31:0] m_rd;
  bit          e_ram_en, e_ram_wr, e_if_rdy, e_mem_rdy;
  logic [31:0] e_addr, e_wdata, e_if_data, e_mem_rd;

  always begin
    @(posedge clock);
    edge_n++;
    if (!reset) begin
      m_busy = 0; m_starve = 0; m_e0 = 0; m_mem = 0; m_wr = 0; m_rd = 0;
      e_ram_en = 0; e_ram_wr = 0; e_if_rdy = 0; e_mem_rdy = 0;
      e_addr = 0; e_wdata = 0; e_if_data = 0; e_mem_rd = 0;
    end else begin
      e_ram_en = 0; e_ram_wr = 0; e_if_rdy = 0; e_mem_rdy = 0;
      if (m_busy && edge_n == m_e0 + LAT) begin
        if (m_mem) begin
          e_mem_rdy = 1;
          e_mem_rd  = m_wr ? 32'h0 : m_rd;
        end else begin
          e_if_rdy  = 1;
          e_if_data = m_rd;
        end
      end
      if (m_busy && edge_n >= m_e0 + LAT + 2) m_busy = 0;
      if (!m_busy) begin
        if (!if_request) m_starve = 0;
        if (if_request || mem_request) begin
          m_mem    = mem_request && !(if_request && m_starve == MAXW);
          m_wr     = m_mem && mem_write;
          e_addr   = m_mem ? mem_address : if_address;
          e_wdata  = m_mem ? mem_write_data : 32'h0;
          m_rd     = ram_lookup(e_addr);
          e_ram_en = 1;
          e_ram_wr = m_wr;
          m_e0     = edge_n;
          m_busy   = 1;
          if (!m_mem) m_starve = 0;
          else if (if_request && m_starve < MAXW) m_starve++;
        end
      end
    end
    #1;
    check("if_ready",       32'(if_ready),    32'(e_if_rdy));
    check("if_data",        if_data,          e_if_data);
    check("mem_ready",      32'(mem_ready),   32'(e_mem_rdy));
    check("mem_read_data",  mem_read_data,    e_mem_rd);
    check("ram_enable",     32'(ram_enable),  32'(e_ram_en));
    check("ram_write",      32'(ram_write),   32'(e_ram_wr));
    check("ram_address",    ram_address,      e_addr);
    check("ram_write_data", ram_write_data,   e_wdata);
    check("stall_if",       32'(stall_if),    32'(if_request & ~e_if_rdy));
    check("stall_mem",      32'(stall_mem),   32'(mem_request & ~e_mem_rdy));
  end

  logic [31:0] grant_log[$];
  always @(negedge clock) if (ram_enable) grant_log.push_back(ram_address);

  // which: 0 = if_ready, 1 = mem_ready, 2 = ram_enable; cyc = negedges waited.
  task automatic wait_sig(input int which, input string name, output int cyc);
    logic s;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      s = (which == 0) ? if_ready : (which == 1) ? mem_ready : ram_enable;
      if (s) begin
        cyc = i;
        return;
      end
    end
    check({name, "_timeout"}, 32'(cyc), 32'd0);
  endtask

  initial begin
    int c, c2, en_cnt;
    logic [31:0] exp_log[$];

    // Reset held with both ports requesting.
    if_request = 1; if_address = 32'h40; mem_request = 1; mem_address = 32'h100;
    en_cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (ram_enable) en_cnt++;
    end
    check("rst_ram_enable_count", 32'(en_cnt), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_ram_address", ram_address, 32'h0);
    if_request = 0; mem_request = 0;
    @(negedge clock);
    reset = 1;
    en_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (ram_enable) en_cnt++;
    end
    check("idle_ram_enable_count", 32'(en_cnt), 32'd0);

    // Fetch read.
    if_request = 1; if_address = 32'h10;
    wait_sig(2, "fetch_issue", c);
    check("fetch_issue_cycle", 32'(c), 32'd1);
    check("fetch_ram_address", ram_address, 32'h10);
    check("fetch_ram_write", 32'(ram_write), 32'd0);
    check("fetch_stall_before", 32'(stall_if), 32'd1);
    wait_sig(0, "fetch_ready", c2);
    check("fetch_ready_cycle", 32'(c2), 32'd2);
    check("fetch_if_data", if_data, 32'h8C01_0004);
    check("fetch_stall_at_ready", 32'(stall_if), 32'd0);
    if_request = 0;
    repeat (2) @(negedge clock);

    // Simultaneous requests: data port first, fetch at E4.
    grant_log.delete();
    if_request = 1; if_address = 32'h40;
    mem_request = 1; mem_write = 0; mem_address = 32'h100; mem_write_data = 32'h1234_5678;
    fork
      begin
        int cm;
        wait_sig(1, "simul_mem", cm);
        mem_request = 0;
        check("simul_mem_cycle", 32'(cm), 32'd3);
        check("simul_mem_data", mem_read_data, 32'hC2C3_0100);
      end
      begin
        int ci;
        wait_sig(0, "simul_if", ci);
        if_request = 0;
        check("simul_if_cycle", 32'(ci), 32'd7);
        check("simul_if_data", if_data, 32'hC383_0040);
      end
    join
    exp_log = '{32'h100, 32'h40};
    check("simul_grant_count", 32'(grant_log.size()), 32'd2);
    foreach (exp_log[i]) if (i < grant_log.size()) check("simul_grant_order", grant_log[i], exp_log[i]);
    repeat (2) @(negedge clock);

    // Starvation: both held; four data grants then one fetch, twice.
    grant_log.delete();
    if_request = 1; mem_request = 1;
    fork
      begin
        int cm;
        repeat (8) wait_sig(1, "starve_mem", cm);
        mem_request = 0;
      end
      begin
        int ci;
        repeat (2) wait_sig(0, "starve_if", ci);
        if_request = 0;
      end
    join
    exp_log = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h40,
                32'h100, 32'h100, 32'h100, 32'h100, 32'h40};
    check("starve_grant_count", 32'(grant_log.size()), 32'd10);
    foreach (exp_log[i]) if (i < grant_log.size()) check("starve_grant_order", grant_log[i], exp_log[i]);
    repeat (2) @(negedge clock);

    // Write, then read the word back through the fetch port.
    mem_request = 1; mem_write = 1; mem_address = 32'h200; mem_write_data = 32'hDEAD_BEEF;
    wait_sig(2, "write_issue", c);
    check("write_ram_write", 32'(ram_write), 32'd1);
    check("write_ram_address", ram_address, 32'h200);
    check("write_ram_wdata", ram_write_data, 32'hDEAD_BEEF);
    wait_sig(1, "write_ready", c2);
    check("write_ready_cycle", 32'(c2), 32'd2);
    check("write_mem_read_data", mem_read_data, 32'h0);
    mem_request = 0; mem_write = 0;
    @(negedge clock);
    check("write_enable_single", 32'(ram_enable), 32'd0);
    @(negedge clock);
    if_request = 1; if_address = 32'h200;
    wait_sig(0, "readback", c);
    check("readback_if_data", if_data, 32'hDEAD_BEEF);
    if_request = 0;
    repeat (2) @(negedge clock);

    // Reset in the WAIT cycle of a fetch.
    if_request = 1; if_address = 32'h10;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 0; if_request = 0;
    en_cnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (if_ready || ram_enable) en_cnt++;
    end
    check("midrst_no_activity", 32'(en_cnt), 32'd0);
    reset = 1;
    repeat (2) @(negedge clock);
    if_request = 1; if_address = 32'h14;
    wait_sig(0, "after_rst", c);
    check("after_rst_cycle", 32'(c), 32'd3);
    check("after_rst_if_data", if_data, 32'hC3D7_0014);
    if_request = 0;
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the pipeline's instruction-fetch port and its data-access port.
- Arbitrates each access, drives the memory with registered signals, and counts the fixed memory latency.
- Returns read data to the granted requester with a one-cycle ready pulse.
- Generates per-port stall signals that feed the pipeline's existing block/stall input.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- MEM_LATENCY, 2, cycles from the memory enable cycle to valid ram_read_data; must be >= 1.
- MAX_WAIT, 4, maximum consecutive data-port grants while the fetch port is waiting; must be >= 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_request  in  1  fetch port requests a read.
- if_address  in  ADDR_WIDTH  fetch address.
- if_ready  out  1  one-cycle pulse: if_data is valid.
- if_data  out  DATA_WIDTH  fetched word.
- mem_request  in  1  data port requests an access.
- mem_write  in  1  1 = write, 0 = read.
- mem_address  in  ADDR_WIDTH  data address.
- mem_write_data  in  DATA_WIDTH  store data.
- mem_ready  out  1  one-cycle pulse: access complete.
- mem_read_data  out  DATA_WIDTH  load data; 0 for writes.
- stall_if  out  1  if_request & ~if_ready (combinational).
- stall_mem  out  1  mem_request & ~mem_ready (combinational).
- ram_enable  out  1  memory access strobe, one cycle per access.
- ram_write  out  1  memory write strobe, qualified by ram_enable.
- ram_address  out  ADDR_WIDTH  memory address.
- ram_write_data  out  DATA_WIDTH  memory write data.
- ram_read_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset:
  - reset low asynchronously forces state IDLE, the latency counter to 0 and the starvation counter to 0.
  - All registered outputs go to 0: if_ready, if_data, mem_ready, mem_read_data, ram_enable, ram_write, ram_address, ram_write_data.
- FSM states and transitions:
  - IDLE: arbitrate. With no request, stay in IDLE; ram_enable stays 0.
  - ISSUE: entered at the grant edge E0. Address, write flag and write data are captured at E0 from the granted port. ram_enable = 1 for this cycle only.
  - WAIT: counts MEM_LATENCY-1 cycles. With MEM_LATENCY=1 this state is skipped.
  - DONE: ram_read_data is sampled at edge E0+MEM_LATENCY and the granted port's ready is raised at that same edge, high for exactly one cycle (E0+MEM_LATENCY to E0+MEM_LATENCY+1), then the FSM returns to IDLE.
  - Latency: ready is high from edge E0+MEM_LATENCY; the next grant edge is no earlier than E0+MEM_LATENCY+2.
- Arbitration (IDLE only):
  - If only one port requests, grant it.
  - If both request, grant the data port, unless the starvation counter equals MAX_WAIT; then grant fetch.
- Starvation counter:
  - Increments on each data-port grant while if_request is high.
  - Clears on a fetch grant, or whenever if_request is low in IDLE.
  - Saturates at MAX_WAIT.
- Handshake rules:
  - A requester holds its request, address and data stable until it sees its ready pulse.
  - A request still high in the IDLE cycle after DONE is treated as a new access.
  - Address and data changes before the grant are allowed; only values at E0 matter.
  - Inputs are ignored outside IDLE.
- Read data:
  - The data word is registered and holds until the same port's next completion.
  - For a write, mem_read_data is loaded with 0 at completion.
- Reset mid-operation: the access in flight is abandoned, no ready pulse is produced, and the next request after release is serviced normally.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, ISSUE, WAIT, DONE).
  - Grant encoding (GRANT_IF, GRANT_MEM).
  - Default MEM_LATENCY and MAX_WAIT constants.
- One sub-module, arbiter_priority_select: combinational fixed-priority select with the starvation override. Inputs are the two requests and the starve flag; output is the grant.
- The FSM, counters and registers stay in the top level.

Test Plan:
- Reset: hold reset=0 with both requests high -> all outputs 0, ram_enable never 1; release with no requests -> ram_enable stays 0 for 10 cycles.
- Fetch read (MEM_LATENCY=2): if_request=1, if_address=0x00000010 sampled at E0, model returns 0x8C010004 -> ram_enable=1 only in cycle E0-E1 with ram_address=0x10, ram_write=0; if_ready high E2-E3 with if_data=0x8C010004; stall_if=1 until then.
- Simultaneous requests: both high at E0, mem read 0x00000100 -> data port granted first (mem_ready E2-E3); fetch granted at E4 (if_ready E6-E7).
- Starvation (MAX_WAIT=4): mem_request and if_request held continuously -> four data-port grants, fifth grant to fetch, then the counter clears and the data port wins again.
- Write: mem_write=1, mem_address=0x00000200, mem_write_data=0xDEADBEEF -> ram_enable=1, ram_write=1, ram_write_data=0xDEADBEEF for one cycle; mem_ready pulse with mem_read_data=0.
- Reset mid-access: reset=0 in the WAIT cycle of a fetch -> no if_ready pulse, ram_enable=0; after release, if_request for 0x14 completes with the normal latency.
